alu_arbiter: RTL and testbench

Shared-ALU arbiter and sequencer for the single-cycle RISC-V core. It lets two requesters share one 32-bit integer ALU over valid/ready handshakes: port 0 is the execute path and port 1 is the branch/address-compute path. Each request goes through a three-state sequence (accept, execute, respond), and the result is held until the winning requester takes it. Grant order is round-robin by default and can be compiled down to fixed priority.

---
 rtl/alu_arbiter.sv | 158 +++++++++++++++
 tb/tb_alu_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port valid/ready arbiter and sequencer around one shared integer ALU
//
// Purpose: two requesters (port 0 execute path, port 1 branch/address path) share a
// single WIDTH-bit ALU. Every request runs accept (IDLE) -> compute (EXEC) -> hold
// result (RESP). The result stays on rsp_result until the granted port consumes it.
//
// Configuration macro: ALU_ARB_RR_EN
//   defined   - round-robin: on contention the priority pointer picks the winner,
//               and the pointer flips to the losing port on every accept.
//   undefined - fixed priority: port 0 always wins contention, no pointer state.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    request handshake (ready is combinational, IDLE only)
//   reqN_in1, reqN_in2         operands, sampled on the handshake edge
//   reqN_ctrl                  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
//   rspN_valid / rspN_ready    response handshake, valid only for the granted port
//   rsp_result                 registered result shared by both ports
//   rsp_zero                   rsp_result == 0
//   rsp_illegal                opcode was unsupported (result forced to 0)

module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_in1,
  input  logic [WIDTH-1:0] req0_in2,
  input  logic [3:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_in1,
  input  logic [WIDTH-1:0] req1_in2,
  input  logic [3:0]       req1_ctrl,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_illegal
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic             grant_q;
  logic [WIDTH-1:0] in1_q;
  logic [WIDTH-1:0] in2_q;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             illegal_q;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;
`ifdef ALU_ARB_RR_EN
  logic             ptr_q;
`endif

  logic             sel1_d;
  logic             accept_d;
  logic             consume_d;
  logic [WIDTH-1:0] alu_result_d;
  logic             alu_illegal_d;

  // Winner selection: a lone valid always wins; on contention the pointer
  // (or port 0 in the fixed-priority build) decides.
  always_comb begin
    sel1_d = 1'b0;
`ifdef ALU_ARB_RR_EN
    sel1_d = req1_valid & (~req0_valid | ptr_q);
`else
    sel1_d = req1_valid & ~req0_valid;
`endif
  end

  assign req0_ready = (state_q == S_IDLE) & req0_valid & ~sel1_d;
  assign req1_ready = (state_q == S_IDLE) & sel1_d;
  assign accept_d   = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  // Only the granted port's ready matters; the other rsp_ready is ignored.
  assign consume_d  = grant_q ? rsp1_ready : rsp0_ready;

  // ALU works only from latched operands, so requesters are free after accept.
  always_comb begin
    alu_result_d  = '0;
    alu_illegal_d = 1'b0;
    case (ctrl_q)
      4'b0000: alu_result_d = in1_q & in2_q;
      4'b0001: alu_result_d = in1_q | in2_q;
      4'b0010: alu_result_d = in1_q + in2_q;
      4'b0110: alu_result_d = in1_q - in2_q;
      default: alu_illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      in1_q        <= '0;
      in2_q        <= '0;
      ctrl_q       <= '0;
      result_q     <= '0;
      zero_q       <= 1'b1;
      illegal_q    <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
      ptr_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            grant_q <= sel1_d;
            in1_q   <= sel1_d ? req1_in1  : req0_in1;
            in2_q   <= sel1_d ? req1_in2  : req0_in2;
            ctrl_q  <= sel1_d ? req1_ctrl : req0_ctrl;
`ifdef ALU_ARB_RR_EN
            ptr_q   <= ~sel1_d;
`endif
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q     <= alu_result_d;
          zero_q       <= (alu_result_d == '0);
          illegal_q    <= alu_illegal_d;
          rsp0_valid_q <= ~grant_q;
          rsp1_valid_q <= grant_q;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (consume_d) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp_result  = result_q;
  assign rsp_zero    = zero_q;
  assign rsp_illegal = illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural reference model

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_illegal;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  // Reference ALU: {illegal, result}, arithmetic done in 64-bit then reduced mod 2^32.
  function automatic logic [32:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint unsigned m  = 64'h1_0000_0000;
    longint unsigned la = a;
    longint unsigned lb = b;
    case (c)
      4'd0:    return {1'b0, a & b};
      4'd1:    return {1'b0, a | b};
      4'd2:    return {1'b0, 32'((la + lb) % m)};
      4'd6:    return {1'b0, 32'((la + m - lb) % m)};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic int ref_winner(input bit v0, input bit v1);
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
`ifdef ALU_ARB_RR_EN
    return m_ptr;
`else
    return 0;
`endif
  endfunction

  task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    if (p == 1) begin
      req1_valid = v; req1_in1 = a; req1_in2 = b; req1_ctrl = c;
    end else begin
      req0_valid = v; req0_in1 = a; req0_in2 = b; req0_ctrl = c;
    end
  endtask

  task automatic set_rsp_ready(input int p, input logic v);
    if (p == 1) rsp1_ready = v;
    else        rsp0_ready = v;
  endtask

  // Presents a request and waits (bounded) for its handshake; returns just after the accept edge.
  task automatic send(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c, output int waited);
    set_req(p, 1'b1, a, b, c);
    #1;
    waited = 0;
    while (((p == 1) ? req1_ready : req0_ready) !== 1'b1 && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    @(posedge clk); #1;
    m_ptr = 1 - p;
    set_req(p, 1'b0, $urandom, $urandom, 4'($urandom));
  endtask

  // Waits (bounded) for the port's response, samples it, then consumes it.
  task automatic collect(input int p, output logic [31:0] res, output logic z, output logic ill,
                         output logic oth, output int lat);
    lat = 0;
    while (((p == 1) ? rsp1_valid : rsp0_valid) !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = rsp_result; z = rsp_zero; ill = rsp_illegal;
    oth = (p == 1) ? rsp0_valid : rsp1_valid;
    set_rsp_ready(p, 1'b1);
    @(posedge clk); #1;
    set_rsp_ready(p, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    m_ptr = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_result !== 32'h0 || rsp_zero !== 1'b1 || rsp_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: result=%h zero=%b illegal=%b required 0/1/0", rsp_result, rsp_zero, rsp_illegal);
    end
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshakes: rsp_valid=%b%b req_ready=%b%b required 00/00", rsp1_valid, rsp0_valid, req1_ready, req0_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: req_ready=%b%b required 00 with no valid", req1_ready, req0_ready);
    end
  endtask

  task automatic test_single_ops;
    logic [31:0] ta[6] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h1234, 32'hF0F0_0F0F, 32'h0000_0010};
    logic [31:0] tb[6] = '{32'h1, 32'd5, 32'h1, 32'h5678, 32'h0FF0_FF00, 32'h0000_0020};
    logic [3:0]  tc[6] = '{4'b0010, 4'b0110, 4'b0010, 4'b1111, 4'b0000, 4'b0110};
    int          tp[6] = '{0, 0, 1, 0, 1, 1};
    logic [31:0] res;
    logic        z, ill, oth;
    logic [32:0] exp;
    int          w, lat;
    for (int i = 0; i < 6; i++) begin
      exp = ref_alu(tc[i], ta[i], tb[i]);
      send(tp[i], ta[i], tb[i], tc[i], w);
      checks++;
      if (w >= 20) begin
        errors++;
        $display("FAIL single_accept[%0d]: no req_ready within %0d cycles", i, w);
      end
      collect(tp[i], res, z, ill, oth, lat);
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL single_latency[%0d]: %0d edges after accept, required 1 (2 cycles from accept edge)", i, lat);
      end
      checks++;
      if (res !== exp[31:0] || z !== (exp[31:0] == 32'h0) || ill !== exp[32] || oth !== 1'b0) begin
        errors++;
        $display("FAIL single_result[%0d]: result=%h zero=%b illegal=%b other_valid=%b required %h/%b/%b/0",
                 i, res, z, ill, oth, exp[31:0], exp[31:0] == 32'h0, exp[32]);
      end
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_consumed[%0d]: rsp_valid=%b%b required 00", i, rsp1_valid, rsp0_valid);
      end
    end
  endtask

  task automatic test_contention;
    logic [32:0] exp;
    int          want, got, n;
    rst_n = 1'b0;
    m_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 4'b0000);
    set_req(1, 1'b1, 32'h0000_000F, 32'h0000_00F0, 4'b0001);
    #1;
    for (int k = 0; k < 4; k++) begin
      want = ref_winner(1'b1, 1'b1);
      checks++;
      if (req0_ready !== (want == 0) || req1_ready !== (want == 1)) begin
        errors++;
        $display("FAIL contention_ready[%0d]: req_ready=%b%b required winner port %0d", k, req1_ready, req0_ready, want);
      end
      @(posedge clk); #1;
      m_ptr = 1 - want;
      n = 0;
      while (!(rsp0_valid === 1'b1 || rsp1_valid === 1'b1) && n < 20) begin
        @(posedge clk); #1; n++;
      end
      got = (rsp1_valid === 1'b1) ? 1 : 0;
      exp = (want == 1) ? ref_alu(4'b0001, 32'h0F, 32'hF0) : ref_alu(4'b0000, 32'hF0F0, 32'hFF00);
      checks++;
      if (n >= 20 || got != want || rsp_result !== exp[31:0]) begin
        errors++;
        $display("FAIL contention_grant[%0d]: port=%0d result=%h required port %0d result %h", k, got, rsp_result, want, exp[31:0]);
      end
      set_rsp_ready(got, 1'b1);
      @(posedge clk); #1;
      set_rsp_ready(got, 1'b0);
    end
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [31:0] a = $urandom, b = $urandom, held, res;
    logic [32:0] exp = ref_alu(4'b0010, a, b);
    logic        z, ill, oth;
    int          w, n, lat;
    send(1, a, b, 4'b0010, w);
    n = 0;
    while (rsp1_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (w >= 20 || n >= 20 || rsp_result !== exp[31:0]) begin
      errors++;
      $display("FAIL bp_response: result=%h waits=%0d/%0d required %h", rsp_result, w, n, exp[31:0]);
    end
    held = rsp_result;
    set_req(0, 1'b1, 32'd9, 32'd4, 4'b0110);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp1_valid !== 1'b1 || rsp_result !== held || req0_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rsp1_valid=%b result=%h req0_ready=%b required 1/%h/0", i, rsp1_valid, rsp_result, req0_ready, held);
      end
    end
    rsp1_ready = 1'b1;
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    checks++;
    if (rsp1_valid !== 1'b0 || req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: rsp1_valid=%b req0_ready=%b required 0/1", rsp1_valid, req0_ready);
    end
    @(posedge clk); #1;
    m_ptr = 1;
    set_req(0, 1'b0, 0, 0, 0);
    collect(0, res, z, ill, oth, lat);
    checks++;
    if (lat >= 20 || res !== 32'd5 || oth !== 1'b0) begin
      errors++;
      $display("FAIL bp_followup: result=%h other_valid=%b latency=%0d required 00000005/0", res, oth, lat);
    end
  endtask

  task automatic test_reset_mid_resp;
    int w, n;
    bit seen = 0;
    send(0, 32'h55, 32'h0F, 4'b0000, w);
    n = 0;
    while (rsp0_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    #2;
    rst_n = 1'b0;
    m_ptr = 0;
    #1;
    checks++;
    if (n >= 20 || rsp0_valid !== 1'b0 || rsp_result !== 32'h0 || rsp_zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_resp: rsp0_valid=%b result=%h zero=%b required 0/0/1", rsp0_valid, rsp_result, rsp_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) seen = 1;
    end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_response: a response appeared after reset release, required none");
    end
  endtask

  task automatic test_random;
    bit          pend[2] = '{0, 0};
    logic [31:0] pa[2], pb[2];
    logic [3:0]  pc[2];
    logic [3:0]  ops[5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0000};
    logic [32:0] exp;
    logic [31:0] held;
    int          want, n, hold;
    for (int r = 0; r < 40; r++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1; pa[p] = $urandom; pb[p] = ($urandom_range(0, 3) == 0) ? pa[p] : $urandom;
          pc[p] = ($urandom_range(0, 5) == 0) ? 4'($urandom) : ops[$urandom_range(0, 3)];
        end
      end
      if (!pend[0] && !pend[1]) begin
        n = $urandom_range(0, 1);
        pend[n] = 1; pa[n] = $urandom; pb[n] = $urandom; pc[n] = 4'b0010;
      end
      for (int p = 0; p < 2; p++) if (pend[p]) set_req(p, 1'b1, pa[p], pb[p], pc[p]);
      #1;
      want = ref_winner(pend[0], pend[1]);
      checks++;
      if (req0_ready !== (want == 0) || req1_ready !== (want == 1)) begin
        errors++;
        $display("FAIL random_ready[%0d]: req_ready=%b%b required winner port %0d", r, req1_ready, req0_ready, want);
      end
      @(posedge clk); #1;
      m_ptr = 1 - want;
      pend[want] = 0;
      exp = ref_alu(pc[want], pa[want], pb[want]);
      set_req(want, 1'b0, $urandom, $urandom, 4'($urandom));
      set_rsp_ready(1 - want, 1'($urandom));
      n = 0;
      while (((want == 1) ? rsp1_valid : rsp0_valid) !== 1'b1 && n < 20) begin
        @(posedge clk); #1; n++;
      end
      checks++;
      if (n >= 20 || rsp_result !== exp[31:0] || rsp_zero !== (exp[31:0] == 32'h0) || rsp_illegal !== exp[32] ||
          ((want == 1) ? rsp0_valid : rsp1_valid) !== 1'b0) begin
        errors++;
        $display("FAIL random_result[%0d]: port=%0d ctrl=%b result=%h zero=%b illegal=%b required %h/%b/%b",
                 r, want, pc[want], rsp_result, rsp_zero, rsp_illegal, exp[31:0], exp[31:0] == 32'h0, exp[32]);
      end
      held = rsp_result;
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        checks++;
        if (((want == 1) ? rsp1_valid : rsp0_valid) !== 1'b1 || rsp_result !== held ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          errors++;
          $display("FAIL random_hold[%0d]: rsp_valid=%b%b result=%h req_ready=%b%b required stable %h, no accept",
                   r, rsp1_valid, rsp0_valid, rsp_result, req1_ready, req0_ready, held);
        end
      end
      set_rsp_ready(want, 1'b1);
      @(posedge clk); #1;
      set_rsp_ready(0, 1'b0);
      set_rsp_ready(1, 1'b0);
    end
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_single_ops;
    test_backpressure;
    test_contention;
    test_reset_mid_resp;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
